// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl
//   Direct-mapped, multi-word-line data cache controller. It sits between a
//   CPU-side request/ready port and a memory-side port that refills whole
//   lines by burst and accepts single-word write-through stores.
//   Writes are write-through and never allocate on a miss. After reset, and
//   on an accepted flush, a sweep clears one valid bit per cycle.
//
// Optional feature: define DM_CACHE_STATS_EN to add the saturating hit_cnt /
//   miss_cnt outputs. Without it those ports do not exist.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   cpu_req / cpu_we        request strobe (sampled in IDLE) / 1 = write
//   cpu_addr / cpu_wdata    word address / write data
//   flush                   invalidate all lines (sampled in IDLE)
//   busy                    high whenever the controller is not IDLE
//   cpu_ready / cpu_hit     one-cycle completion pulse / request hit
//   cpu_rdata               read data, held until the next completion
//   mem_req / mem_we        memory request (held) / 1 = word write, 0 = burst
//   mem_addr / mem_wdata    line base (read) or word address (write) / data
//   mem_rvalid / mem_rdata  one refill beat per cycle, ascending offsets
//   mem_wack                write accepted
//   hit_cnt / miss_cnt      completed hits / misses (DM_CACHE_STATS_EN only)
module dm_cache_ctrl #(
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 10,
    parameter int LINE_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              flush,
    output logic              busy,
    output logic              cpu_ready,
    output logic              cpu_hit,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_wack
`ifdef DM_CACHE_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);

    localparam int TAG_W = ADDR_W - INDEX_W - LINE_W;
    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << (INDEX_W + LINE_W);

    localparam logic [2:0] SWEEP  = 3'd0;
    localparam logic [2:0] IDLE   = 3'd1;
    localparam logic [2:0] LOOKUP = 3'd2;
    localparam logic [2:0] FILL   = 3'd3;
    localparam logic [2:0] WTHRU  = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [INDEX_W-1:0] sweepCnt_q;
    logic [LINE_W-1:0]  beat_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               we_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               busy_q;
    logic               cpuHit_q;
    logic [DATA_W-1:0]  cpuRdata_q;
    logic               memReq_q;
    logic               memWe_q;
    logic [ADDR_W-1:0]  memAddr_q;
    logic [DATA_W-1:0]  memWdata_q;

    // Storage arrays carry no reset; the sweep is what invalidates lines.
    logic [DATA_W-1:0]  dataMem [WORDS];
    logic [TAG_W-1:0]   tagMem  [LINES];
    logic [LINES-1:0]   valid_q;

    logic [INDEX_W-1:0] reqIdx;
    logic [LINE_W-1:0]  reqOff;
    logic [TAG_W-1:0]   reqTag;
    logic               lookupHit;
    logic               lastBeat;
    logic               sweepLast;

    assign reqIdx    = addr_q[LINE_W+INDEX_W-1:LINE_W];
    assign reqOff    = addr_q[LINE_W-1:0];
    assign reqTag    = addr_q[ADDR_W-1:ADDR_W-TAG_W];
    assign lookupHit = valid_q[reqIdx] && (tagMem[reqIdx] == reqTag);
    assign lastBeat  = mem_rvalid && (beat_q == {LINE_W{1'b1}});
    assign sweepLast = (sweepCnt_q == {INDEX_W{1'b1}});

    always_comb begin
        state_d = state_q;
        case (state_q)
            SWEEP:   if (sweepLast) state_d = IDLE;
            IDLE: begin
                if (flush)        state_d = SWEEP;
                else if (cpu_req) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (we_q)           state_d = WTHRU;
                else if (lookupHit) state_d = DONE;
                else                state_d = FILL;
            end
            FILL:    if (lastBeat) state_d = DONE;
            WTHRU:   if (mem_wack) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // busy is registered from the next state so that it reads 0 while reset
    // is asserted and rises on the first clock edge of the sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SWEEP;
            sweepCnt_q <= '0;
            beat_q     <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            cpuHit_q   <= 1'b0;
            cpuRdata_q <= '0;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            case (state_q)
                SWEEP: sweepCnt_q <= sweepCnt_q + 1'b1;
                IDLE: begin
                    if (flush) begin
                        sweepCnt_q <= '0;
                    end else if (cpu_req) begin
                        addr_q  <= cpu_addr;
                        we_q    <= cpu_we;
                        wdata_q <= cpu_wdata;
                    end
                end
                LOOKUP: begin
                    if (we_q) begin
                        memReq_q   <= 1'b1;
                        memWe_q    <= 1'b1;
                        memAddr_q  <= addr_q;
                        memWdata_q <= wdata_q;
                        cpuHit_q   <= lookupHit;
                    end else if (lookupHit) begin
                        cpuRdata_q <= dataMem[{reqIdx, reqOff}];
                        cpuHit_q   <= 1'b1;
                    end else begin
                        memReq_q  <= 1'b1;
                        memWe_q   <= 1'b0;
                        memAddr_q <= {addr_q[ADDR_W-1:LINE_W], {LINE_W{1'b0}}};
                        beat_q    <= '0;
                    end
                end
                FILL: begin
                    if (mem_rvalid) begin
                        beat_q <= beat_q + 1'b1;
                        if (beat_q == reqOff) cpuRdata_q <= mem_rdata;
                        if (lastBeat) begin
                            memReq_q <= 1'b0;
                            cpuHit_q <= 1'b0;
                        end
                    end
                end
                WTHRU: if (mem_wack) memReq_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // Array updates: sweep invalidation, write-hit update, and refill beats.
    // The tag and valid bit are only committed with the final beat, so a
    // partially refilled line never looks valid.
    always_ff @(posedge clk) begin
        if (state_q == SWEEP) valid_q[sweepCnt_q] <= 1'b0;
        if (state_q == LOOKUP && we_q && lookupHit)
            dataMem[{reqIdx, reqOff}] <= wdata_q;
        if (state_q == FILL && mem_rvalid) begin
            dataMem[{reqIdx, beat_q}] <= mem_rdata;
            if (lastBeat) begin
                tagMem[reqIdx]  <= reqTag;
                valid_q[reqIdx] <= 1'b1;
            end
        end
    end

`ifdef DM_CACHE_STATS_EN
    logic [15:0] hitCnt_q, missCnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hitCnt_q  <= '0;
            missCnt_q <= '0;
        end else if (state_q == IDLE && flush) begin
            hitCnt_q  <= '0;
            missCnt_q <= '0;
        end else if (state_q == DONE) begin
            if (cpuHit_q) begin
                if (hitCnt_q != 16'hFFFF) hitCnt_q <= hitCnt_q + 16'd1;
            end else begin
                if (missCnt_q != 16'hFFFF) missCnt_q <= missCnt_q + 16'd1;
            end
        end
    end

    assign hit_cnt  = hitCnt_q;
    assign miss_cnt = missCnt_q;
`endif

    assign busy      = busy_q;
    assign cpu_ready = (state_q == DONE);
    assign cpu_hit   = cpuHit_q;
    assign cpu_rdata = cpuRdata_q;
    assign mem_req   = memReq_q;
    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl
//   Directed bench for dm_cache_ctrl with default parameters
//   (15-bit address, 32-bit data, 1024 lines of 4 words, 3-bit tag).
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge. "Cycle n" below is the n-th falling edge after the edge that
//   sampled cpu_req.
module tb_dm_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, flush;
    logic [14:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        busy, cpu_ready, cpu_hit;
    logic [31:0] cpu_rdata;
    logic        mem_req, mem_we;
    logic [14:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid, mem_wack;
    logic [31:0] mem_rdata;
`ifdef DM_CACHE_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    dm_cache_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .flush      (flush),
        .busy       (busy),
        .cpu_ready  (cpu_ready),
        .cpu_hit    (cpu_hit),
        .cpu_rdata  (cpu_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_wack   (mem_wack)
`ifdef DM_CACHE_STATS_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Presents one request for exactly one rising edge; returns at cycle 1.
    task automatic applyStimulus(input logic we, input logic [14:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        @(negedge clk);
        cpu_req = 1'b0;
    endtask

    // Counts falling edges with busy high, starting at the current one.
    task automatic countBusy(output int n, output logic sawMemReq);
        n = 0;
        sawMemReq = 1'b0;
        while (busy && n < 3000) begin
            n++;
            sawMemReq |= mem_req;
            @(negedge clk);
        end
    endtask

    // Hit: LOOKUP in cycle 1, DONE (cpu_ready) in cycle 2.
    task automatic readHit(input string tag, input logic [14:0] addr, input logic [31:0] expData);
        applyStimulus(1'b0, addr, 32'h0);
        checkOutput({tag, "_ready_c1"}, cpu_ready, 0);
        @(negedge clk);
        checkOutput({tag, "_ready_c2"}, cpu_ready, 1);
        checkOutput({tag, "_hit"}, cpu_hit, 1);
        checkOutput({tag, "_rdata"}, cpu_rdata, expData);
        checkOutput({tag, "_memreq"}, mem_req, 0);
        @(negedge clk);
        checkOutput({tag, "_ready_pulse"}, cpu_ready, 0);
    endtask

    // Miss: FILL from cycle 2, beats base+0..base+3, optional stall after beat 1.
    task automatic readMiss(input string tag, input logic [14:0] addr, input logic [31:0] base,
                            input logic stall);
        logic [32:0] beats [5];
        int nBeats;
        beats[0] = {1'b1, base};
        beats[1] = {1'b1, base + 32'd1};
        if (stall) begin
            beats[2] = {1'b0, 32'h0};
            beats[3] = {1'b1, base + 32'd2};
            beats[4] = {1'b1, base + 32'd3};
            nBeats = 5;
        end else begin
            beats[2] = {1'b1, base + 32'd2};
            beats[3] = {1'b1, base + 32'd3};
            beats[4] = '0;
            nBeats = 4;
        end
        applyStimulus(1'b0, addr, 32'h0);
        checkOutput({tag, "_busy"}, busy, 1);
        checkOutput({tag, "_memreq_c1"}, mem_req, 0);
        @(negedge clk);
        checkOutput({tag, "_memreq"}, mem_req, 1);
        checkOutput({tag, "_memwe"}, mem_we, 0);
        checkOutput({tag, "_memaddr"}, mem_addr, {addr[14:2], 2'b00});
        for (int i = 0; i < nBeats; i++) begin
            checkOutput({tag, "_ready_fill"}, cpu_ready, 0);
            mem_rvalid = beats[i][32];
            mem_rdata  = beats[i][31:0];
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
        checkOutput({tag, "_ready"}, cpu_ready, 1);
        checkOutput({tag, "_hit"}, cpu_hit, 0);
        checkOutput({tag, "_rdata"}, cpu_rdata, base + 32'(addr[1:0]));
        checkOutput({tag, "_memreq_drop"}, mem_req, 0);
        @(negedge clk);
        checkOutput({tag, "_ready_pulse"}, cpu_ready, 0);
    endtask

    // Write: WTHRU from cycle 2, ack driven in cycle 3, DONE in cycle 4.
    task automatic writeThru(input string tag, input logic [14:0] addr, input logic [31:0] data,
                             input logic expHit);
        applyStimulus(1'b1, addr, data);
        @(negedge clk);
        checkOutput({tag, "_memreq"}, mem_req, 1);
        checkOutput({tag, "_memwe"}, mem_we, 1);
        checkOutput({tag, "_memaddr"}, mem_addr, addr);
        checkOutput({tag, "_memwdata"}, mem_wdata, data);
        @(negedge clk);
        checkOutput({tag, "_memreq_hold"}, mem_req, 1);
        checkOutput({tag, "_ready_wait"}, cpu_ready, 0);
        mem_wack = 1'b1;
        @(negedge clk);
        mem_wack = 1'b0;
        checkOutput({tag, "_ready"}, cpu_ready, 1);
        checkOutput({tag, "_hit"}, cpu_hit, expHit);
        checkOutput({tag, "_memreq_drop"}, mem_req, 0);
        @(negedge clk);
        checkOutput({tag, "_ready_pulse"}, cpu_ready, 0);
    endtask

    initial begin
        int n;
        logic sawReq;
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; flush = 1'b0;
        cpu_addr = '0; cpu_wdata = '0;
        mem_rvalid = 1'b0; mem_rdata = '0; mem_wack = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ready", cpu_ready, 0);
        checkOutput("rst_rdata", cpu_rdata, 0);
        checkOutput("rst_memreq", mem_req, 0);
        checkOutput("rst_memaddr", mem_addr, 0);

        // Reset in the middle of a sweep, then the full restarted sweep:
        // edges 1..1024 sweep, busy reads high after edges 1..1023.
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        checkOutput("midsweep_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midsweep_rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        countBusy(n, sawReq);
        checkOutput("sweep_len", n, 1023);
        checkOutput("sweep_memreq", sawReq, 0);

        readMiss("rd5_miss", 15'h0005, 32'hA0, 1'b1);
        readHit("rd7_hit", 15'h0007, 32'hA3);
        writeThru("wr6_hit", 15'h0006, 32'hDEAD, 1'b1);
        readHit("rd6_hit", 15'h0006, 32'hDEAD);
        writeThru("wr1006_miss", 15'h1006, 32'hBEEF, 1'b0);
`ifdef DM_CACHE_STATS_EN
        checkOutput("stats_hit", hit_cnt, 3);
        checkOutput("stats_miss", miss_cnt, 2);
`endif
        readHit("rd6_after_miss", 15'h0006, 32'hDEAD);
`ifdef DM_CACHE_STATS_EN
        checkOutput("stats_hit4", hit_cnt, 4);
`endif

        // flush and cpu_req together: flush wins, request dropped.
        @(negedge clk);
        flush = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0005;
        @(negedge clk);
        flush = 1'b0; cpu_req = 1'b0;
        countBusy(n, sawReq);
        checkOutput("flush_len", n, 1024);
        checkOutput("flush_memreq", sawReq, 0);
        checkOutput("flush_ready", cpu_ready, 0);
`ifdef DM_CACHE_STATS_EN
        checkOutput("flush_stats_hit", hit_cnt, 0);
        checkOutput("flush_stats_miss", miss_cnt, 0);
`endif
        readMiss("rd5_after_flush", 15'h0005, 32'hB0, 1'b0);
`ifdef DM_CACHE_STATS_EN
        checkOutput("stats_miss_after_flush", miss_cnt, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
